// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: generic pipeline stage buffer with valid/ready handshake,
// optional two-entry skid buffering, synchronous flush-to-bubble, a
// memory-request sideband that self-clears on a hit, and a saturating
// stall counter.
module pipe_stage_buf #(
  parameter int                 DATA_W = 128,
  parameter int                 REQ_W  = 2,
  parameter logic [DATA_W-1:0]  BUBBLE = {DATA_W{1'b0}},
  parameter int                 SKID   = 1,
  parameter int                 CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [REQ_W-1:0]  in_req,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [REQ_W-1:0]  out_req,
  input  logic              mem_hit,
  input  logic              flush,
  output logic [CNT_W-1:0]  stall_cnt,
  input  logic              clr_cnt
);

  localparam logic [REQ_W-1:0] REQ_NONE = {REQ_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  // Head entry (visible downstream) and skid entry (only used when SKID != 0).
  logic              r_head_valid;
  logic [DATA_W-1:0] r_head_data;
  logic [REQ_W-1:0]  r_head_req;
  logic              r_skid_valid;
  logic [DATA_W-1:0] r_skid_data;
  logic [REQ_W-1:0]  r_skid_req;
  logic [CNT_W-1:0]  r_stall_cnt;

  logic              w_head_valid_nx;
  logic [DATA_W-1:0] w_head_data_nx;
  logic [REQ_W-1:0]  w_head_req_nx;
  logic              w_skid_valid_nx;
  logic [DATA_W-1:0] w_skid_data_nx;
  logic [REQ_W-1:0]  w_skid_req_nx;
  logic              w_in_ready;
  logic              w_accept;
  logic              w_pop;
  logic              w_hit_clr;
  logic              w_stall;

  // With a skid entry in_ready comes straight from a register; without one
  // the stage may accept whenever the head is empty or leaving.
  assign w_in_ready = (SKID != 0) ? !r_skid_valid : (!r_head_valid || out_ready);
  assign w_accept   = in_valid && w_in_ready;
  assign w_pop      = r_head_valid && out_ready;
  assign w_hit_clr  = mem_hit && r_head_valid;
  assign w_stall    = r_head_valid && !out_ready;

  assign in_ready  = w_in_ready;
  assign out_valid = r_head_valid;
  assign out_data  = r_head_data;
  assign out_req   = r_head_req;
  assign stall_cnt = r_stall_cnt;

  // Next-state selection for head and skid entries; flush dominates, then a
  // skid-to-head transfer, then loading the head, then loading the skid.
  always_comb begin
    w_head_valid_nx = r_head_valid;
    w_head_data_nx  = r_head_data;
    w_head_req_nx   = r_head_req;
    w_skid_valid_nx = r_skid_valid;
    w_skid_data_nx  = r_skid_data;
    w_skid_req_nx   = r_skid_req;
    if (flush) begin
      w_head_valid_nx = 1'b0;
      w_head_data_nx  = BUBBLE;
      w_head_req_nx   = REQ_NONE;
      w_skid_valid_nx = 1'b0;
      w_skid_data_nx  = BUBBLE;
      w_skid_req_nx   = REQ_NONE;
    end else if ((SKID != 0) && w_pop && r_skid_valid) begin
      // in_ready is low here, so no input competes for the head
      w_head_valid_nx = 1'b1;
      w_head_data_nx  = r_skid_data;
      w_head_req_nx   = r_skid_req;
      w_skid_valid_nx = 1'b0;
      w_skid_req_nx   = REQ_NONE;
    end else if (w_accept && (!r_head_valid || w_pop)) begin
      // a replacement wins over a concurrent hit on the old head
      w_head_valid_nx = 1'b1;
      w_head_data_nx  = in_data;
      w_head_req_nx   = in_req;
    end else if (w_accept) begin
      // head full and held: park the input behind it
      w_skid_valid_nx = 1'b1;
      w_skid_data_nx  = in_data;
      w_skid_req_nx   = in_req;
      if (w_hit_clr) begin
        w_head_req_nx = REQ_NONE;
      end else begin
        w_head_req_nx = r_head_req;
      end
    end else if (w_pop) begin
      w_head_valid_nx = 1'b0;
      w_head_req_nx   = REQ_NONE;
    end else if (w_hit_clr) begin
      w_head_req_nx = REQ_NONE;
    end else begin
      w_head_valid_nx = r_head_valid;
    end
  end

  // Entry registers; reset drops everything back to the bubble.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_head_valid <= 1'b0;
      r_head_data  <= BUBBLE;
      r_head_req   <= REQ_NONE;
      r_skid_valid <= 1'b0;
      r_skid_data  <= BUBBLE;
      r_skid_req   <= REQ_NONE;
    end else begin
      r_head_valid <= w_head_valid_nx;
      r_head_data  <= w_head_data_nx;
      r_head_req   <= w_head_req_nx;
      r_skid_valid <= w_skid_valid_nx;
      r_skid_data  <= w_skid_data_nx;
      r_skid_req   <= w_skid_req_nx;
    end
  end

  // Saturating stall counter; clear beats increment, flush leaves it alone.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_stall_cnt <= CNT_ZERO;
    end else if (clr_cnt) begin
      r_stall_cnt <= CNT_ZERO;
    end else if (w_stall && !(&r_stall_cnt)) begin
      r_stall_cnt <= r_stall_cnt + CNT_ONE;
    end else begin
      r_stall_cnt <= r_stall_cnt;
    end
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed self-checking bench for pipe_stage_buf: one skid-buffered
// instance (small counter) and one single-register instance fed the same
// inputs, the latter checked only in the streaming case.
module tb_pipe_stage_buf;

  localparam int          DW  = 16;
  localparam logic [15:0] BUB = 16'hB0B0;

  logic          CLK;
  logic          nRST;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic [1:0]    in_req;
  logic          out_ready;
  logic          mem_hit;
  logic          flush;
  logic          clr_cnt;

  logic          in_ready_s, out_valid_s;
  logic [DW-1:0] out_data_s;
  logic [1:0]    out_req_s;
  logic [3:0]    stall_cnt_s;

  logic          in_ready_z, out_valid_z;
  logic [DW-1:0] out_data_z;
  logic [1:0]    out_req_z;
  logic [3:0]    stall_cnt_z;

  int n_checks = 0;
  int n_errors = 0;

  pipe_stage_buf #(.DATA_W(DW), .REQ_W(2), .BUBBLE(BUB), .SKID(1), .CNT_W(4)) u_dut (
    .CLK(CLK), .nRST(nRST),
    .in_valid(in_valid), .in_ready(in_ready_s), .in_data(in_data), .in_req(in_req),
    .out_valid(out_valid_s), .out_ready(out_ready), .out_data(out_data_s), .out_req(out_req_s),
    .mem_hit(mem_hit), .flush(flush), .stall_cnt(stall_cnt_s), .clr_cnt(clr_cnt)
  );

  pipe_stage_buf #(.DATA_W(DW), .REQ_W(2), .BUBBLE(BUB), .SKID(0), .CNT_W(4)) u_dut0 (
    .CLK(CLK), .nRST(nRST),
    .in_valid(in_valid), .in_ready(in_ready_z), .in_data(in_data), .in_req(in_req),
    .out_valid(out_valid_z), .out_ready(out_ready), .out_data(out_data_z), .out_req(out_req_z),
    .mem_hit(mem_hit), .flush(flush), .stall_cnt(stall_cnt_z), .clr_cnt(clr_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic [1:0] r);
    in_valid = v;
    in_data  = d;
    in_req   = r;
  endtask

  initial begin
    nRST = 1'b0; flush = 1'b0; mem_hit = 1'b0; clr_cnt = 1'b0; out_ready = 1'b0;
    drive(1'b0, 16'h0000, 2'b00);
    #12;
    chk("rst_valid", {31'd0, out_valid_s}, 32'd0);
    chk("rst_data",  {16'd0, out_data_s}, {16'd0, BUB});
    chk("rst_req",   {30'd0, out_req_s}, 32'd0);
    chk("rst_ready", {31'd0, in_ready_s}, 32'd1);
    chk("rst_cnt",   {28'd0, stall_cnt_s}, 32'd0);
    chk("rst0_data", {16'd0, out_data_z}, {16'd0, BUB});
    nRST = 1'b1;
    tick();

    // streaming, both variants
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 16'(i), 2'b00);
      chk("str_rdy",  {31'd0, in_ready_s}, 32'd1);
      chk("str0_rdy", {31'd0, in_ready_z}, 32'd1);
      tick();
      chk("str_valid",  {31'd0, out_valid_s}, 32'd1);
      chk("str_data",   {16'd0, out_data_s}, 32'(i));
      chk("str0_valid", {31'd0, out_valid_z}, 32'd1);
      chk("str0_data",  {16'd0, out_data_z}, 32'(i));
    end
    drive(1'b0, 16'h0000, 2'b00);
    tick();
    chk("str_end",   {31'd0, out_valid_s}, 32'd0);
    chk("str0_end",  {31'd0, out_valid_z}, 32'd0);
    chk("str_cnt",   {28'd0, stall_cnt_s}, 32'd0);
    chk("str0_cnt",  {28'd0, stall_cnt_z}, 32'd0);

    // skid fill, request clear, drain
    out_ready = 1'b0;
    drive(1'b1, 16'h000A, 2'b10);
    tick();
    chk("sk_headA", {16'd0, out_data_s}, 32'h000A);
    drive(1'b1, 16'h000B, 2'b01);
    tick();
    chk("sk_full_rdy", {31'd0, in_ready_s}, 32'd0);
    chk("sk_headA2", {16'd0, out_data_s}, 32'h000A);
    chk("sk_reqA",   {30'd0, out_req_s}, 32'h2);
    drive(1'b1, 16'h000C, 2'b11);
    mem_hit = 1'b1;
    tick();
    mem_hit = 1'b0;
    chk("hit_req",   {30'd0, out_req_s}, 32'h0);
    chk("hit_data",  {16'd0, out_data_s}, 32'h000A);
    chk("hit_valid", {31'd0, out_valid_s}, 32'd1);
    tick();
    chk("sk_cnt3",   {28'd0, stall_cnt_s}, 32'd3);
    chk("sk_rdy0",   {31'd0, in_ready_s}, 32'd0);
    out_ready = 1'b1;
    tick();
    chk("dr_dataB",  {16'd0, out_data_s}, 32'h000B);
    chk("dr_reqB",   {30'd0, out_req_s}, 32'h1);
    chk("dr_rdy",    {31'd0, in_ready_s}, 32'd1);
    chk("dr_cnt",    {28'd0, stall_cnt_s}, 32'd3);
    tick();
    chk("dr_dataC",  {16'd0, out_data_s}, 32'h000C);
    chk("dr_reqC",   {30'd0, out_req_s}, 32'h3);
    drive(1'b0, 16'h0000, 2'b00);
    tick();
    chk("dr_empty",  {31'd0, out_valid_s}, 32'd0);

    // flush with head and skid full
    out_ready = 1'b0;
    drive(1'b1, 16'h000D, 2'b10);
    tick();
    drive(1'b1, 16'h000E, 2'b01);
    tick();
    chk("fl_full",   {31'd0, in_ready_s}, 32'd0);
    drive(1'b1, 16'h000F, 2'b11);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl_valid",  {31'd0, out_valid_s}, 32'd0);
    chk("fl_data",   {16'd0, out_data_s}, {16'd0, BUB});
    chk("fl_req",    {30'd0, out_req_s}, 32'h0);
    chk("fl_rdy",    {31'd0, in_ready_s}, 32'd1);
    drive(1'b1, 16'h0011, 2'b11);
    tick();
    chk("fl_newG",   {16'd0, out_data_s}, 32'h0011);
    drive(1'b1, 16'h0022, 2'b10);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl2_valid", {31'd0, out_valid_s}, 32'd0);
    chk("fl2_rdy",   {31'd0, in_ready_s}, 32'd1);
    drive(1'b0, 16'h0000, 2'b00);
    out_ready = 1'b1;
    tick();
    chk("fl_quiet",  {31'd0, out_valid_s}, 32'd0);

    // counter saturation and clear
    out_ready = 1'b0;
    clr_cnt = 1'b1;
    drive(1'b1, 16'h0055, 2'b10);
    tick();
    clr_cnt = 1'b0;
    chk("cnt_clr0",  {28'd0, stall_cnt_s}, 32'd0);
    drive(1'b1, 16'h0066, 2'b01);
    for (int i = 0; i < 20; i++) begin
      tick();
      drive(1'b0, 16'h0000, 2'b00);
    end
    chk("cnt_sat",   {28'd0, stall_cnt_s}, 32'd15);
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    chk("cnt_clr",   {28'd0, stall_cnt_s}, 32'd0);
    tick();
    chk("cnt_resume", {28'd0, stall_cnt_s}, 32'd1);

    // asynchronous reset mid-stall with request pending and skid full
    chk("ar_pre_req", {30'd0, out_req_s}, 32'h2);
    #2;
    nRST = 1'b0;
    #1;
    chk("ar_valid",  {31'd0, out_valid_s}, 32'd0);
    chk("ar_data",   {16'd0, out_data_s}, {16'd0, BUB});
    chk("ar_req",    {30'd0, out_req_s}, 32'h0);
    chk("ar_rdy",    {31'd0, in_ready_s}, 32'd1);
    chk("ar_cnt",    {28'd0, stall_cnt_s}, 32'd0);
    #3;
    nRST = 1'b1;
    tick();
    chk("ar_after",  {31'd0, out_valid_s}, 32'd0);
    chk("ar_cnt2",   {28'd0, stall_cnt_s}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
